// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types and helpers for the data-cache request arbiter.
// Contents: arb_state_e (IDLE/BUSY), default index width, rr_pick()
// round-robin selection helper usable by any arbiter up to MAX_REQ inputs.
package dcache_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned IDX_W     = $clog2(NREQ_DEF);
  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  // First set bit of valid[n-1:0] scanning ptr, ptr+1, ... mod n; 0 if none set.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_IDX_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if ((i < n) && !found && valid[idx[MAX_IDX_W-1:0]]) begin
        pick  = idx[MAX_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dcache_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter (N <= MAX_REQ).
// Ports: req   - request vector
//        ptr   - highest-priority index this cycle
//        gnt   - one-hot grant, all zero when no request
//        gnt_idx - binary index of the grant (0 when no request)
module rr_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [MAX_IDX_W-1:0] w_pick;

  always_comb w_pick = rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr), N);

  assign gnt_idx = W'(w_pick);
  assign gnt     = (|req) ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one data-cache port among NREQ requesters.
// One request in flight at a time; the response is routed to its owner and a
// watchdog retires requests the cache never answers.
// Ports: rq_*      - per-requester valid/ready, packed addr/write/wdata
//        rsp_*     - one-hot response pulse, read data, watchdog-retire flag
//        dc_req_*  - request toward the cache (fields registered)
//        dc_resp_* - cache response pulse and read data
//        err_*     - sticky timeout / spurious-response flags
module dcache_req_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        rq_valid,
  output logic [NREQ-1:0]        rq_ready,
  input  logic [NREQ*ADDR_W-1:0] rq_addr,
  input  logic [NREQ-1:0]        rq_write,
  input  logic [NREQ*DATA_W-1:0] rq_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   dc_req_valid,
  output logic [ADDR_W-1:0]      dc_req_addr,
  output logic                   dc_req_write,
  output logic [DATA_W-1:0]      dc_req_wdata,
  input  logic                   dc_resp_valid,
  input  logic [DATA_W-1:0]      dc_resp_rdata,
  output logic                   err_timeout,
  output logic                   err_spurious
);

  localparam int unsigned RR_W = $clog2(NREQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  arb_state_e          r_state,     w_state_nxt;
  logic [RR_W-1:0]     r_rr_ptr,    w_rr_ptr_nxt;
  logic [RR_W-1:0]     r_owner,     w_owner_nxt;
  logic [WD_W-1:0]     r_wd_cnt,    w_wd_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic                r_write,     w_write_nxt;
  logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;
  logic [NREQ-1:0]     r_rsp_valid, w_rsp_valid_nxt;
  logic                r_rsp_err,   w_rsp_err_nxt;
  logic [DATA_W-1:0]   r_rdata,     w_rdata_nxt;
  logic                r_err_to,    w_err_to_nxt;
  logic                r_err_sp,    w_err_sp_nxt;

  logic [NREQ-1:0]     w_gnt;
  logic [RR_W-1:0]     w_gnt_idx;

  rr_arbiter #(.N(NREQ), .W(RR_W)) u_rr (
    .req     (rq_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign rq_ready     = (r_state == IDLE) ? w_gnt : '0;
  // Dropped in the response cycle so the cache never samples the request twice.
  assign dc_req_valid = (r_state == BUSY) & ~dc_resp_valid;

  assign dc_req_addr  = r_addr;
  assign dc_req_write = r_write;
  assign dc_req_wdata = r_wdata;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_rdata    = r_rdata;
  assign err_timeout  = r_err_to;
  assign err_spurious = r_err_sp;

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_wd_cnt_nxt    = r_wd_cnt;
    w_addr_nxt      = r_addr;
    w_write_nxt     = r_write;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_err_to_nxt    = r_err_to;
    w_err_sp_nxt    = r_err_sp;
    if (r_state == IDLE) begin
      if (dc_resp_valid) w_err_sp_nxt = 1'b1;
      if (|rq_valid) begin
        w_addr_nxt   = rq_addr[32'(w_gnt_idx)*ADDR_W +: ADDR_W];
        w_write_nxt  = rq_write[w_gnt_idx];
        w_wdata_nxt  = rq_wdata[32'(w_gnt_idx)*DATA_W +: DATA_W];
        w_owner_nxt  = w_gnt_idx;
        w_rr_ptr_nxt = (w_gnt_idx == RR_W'(NREQ-1)) ? '0 : w_gnt_idx + RR_W'(1);
        w_wd_cnt_nxt = '0;
        w_state_nxt  = BUSY;
      end
    end else begin
      if (dc_resp_valid) begin
        w_rsp_valid_nxt = NREQ'(1) << r_owner;
        w_rdata_nxt     = dc_resp_rdata;
        w_state_nxt     = IDLE;
      end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC-1)) begin
        w_rsp_valid_nxt = NREQ'(1) << r_owner;
        w_rsp_err_nxt   = 1'b1;
        w_rdata_nxt     = '0;
        w_err_to_nxt    = 1'b1;
        w_state_nxt     = IDLE;
      end else begin
        w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_wd_cnt    <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
      r_err_to    <= 1'b0;
      r_err_sp    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_wd_cnt    <= w_wd_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_write     <= w_write_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err_to    <= w_err_to_nxt;
      r_err_sp    <= w_err_sp_nxt;
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_dcache_req_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TO     = 24;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        rq_valid;
  logic [NREQ-1:0]        rq_ready;
  logic [NREQ*ADDR_W-1:0] rq_addr;
  logic [NREQ-1:0]        rq_write;
  logic [NREQ*DATA_W-1:0] rq_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   dc_req_valid;
  logic [ADDR_W-1:0]      dc_req_addr;
  logic                   dc_req_write;
  logic [DATA_W-1:0]      dc_req_wdata;
  logic                   dc_resp_valid;
  logic [DATA_W-1:0]      dc_resp_rdata;
  logic                   err_timeout;
  logic                   err_spurious;

  always #5 clk = ~clk;

  dcache_req_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
    .rq_write(rq_write), .rq_wdata(rq_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_write(dc_req_write), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: one outstanding transaction plus sticky flags.
  bit                m_busy;
  int                m_ptr;
  int                m_owner;
  int                m_age;
  logic [ADDR_W-1:0] m_addr;
  logic              m_write;
  logic [DATA_W-1:0] m_wdata;
  logic [NREQ-1:0]   m_rsp_valid;
  logic              m_rsp_err;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err_to;
  logic              m_err_sp;

  // Cache behaviour: answer plan_lat cycles after the request first appears.
  int                plan_lat;
  int                next_lat;
  bit                spur;
  logic [DATA_W-1:0] resp_data;
  int                grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0; m_age = 0;
    m_addr = '0; m_write = 1'b0; m_wdata = '0;
    m_rsp_valid = '0; m_rsp_err = 1'b0; m_rdata = '0;
    m_err_to = 1'b0; m_err_sp = 1'b0;
  endtask

  function automatic int pick_winner();
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(NREQ);
      if (rq_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic w,
                         input logic [DATA_W-1:0] d);
    rq_addr[i*ADDR_W +: ADDR_W]  = a;
    rq_write[i]                  = w;
    rq_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // One clock cycle: drive cache, check everything at negedge, advance model.
  task automatic step();
    int              w;
    logic [NREQ-1:0] exp_ready;
    dc_resp_valid = (m_busy && (m_age == plan_lat)) || (!m_busy && spur);
    dc_resp_rdata = resp_data;
    @(negedge clk);
    w = m_busy ? -1 : pick_winner();
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    chk("rq_ready", 64'(rq_ready), 64'(exp_ready));
    chk("dc_req_valid", 64'(dc_req_valid), 64'(m_busy && !dc_resp_valid));
    if (m_busy) begin
      chk("dc_req_addr", 64'(dc_req_addr), 64'(m_addr));
      chk("dc_req_write", 64'(dc_req_write), 64'(m_write));
      chk("dc_req_wdata", dc_req_wdata, m_wdata);
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
    chk("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("err_timeout", 64'(err_timeout), 64'(m_err_to));
    chk("err_spurious", 64'(err_spurious), 64'(m_err_sp));
    m_rsp_valid = '0;
    m_rsp_err   = 1'b0;
    if (m_busy) begin
      if (dc_resp_valid) begin
        m_rsp_valid = NREQ'(1) << m_owner;
        m_rdata     = dc_resp_rdata;
        m_busy      = 0;
      end else if (m_age == int'(TO) - 1) begin
        m_rsp_valid = NREQ'(1) << m_owner;
        m_rsp_err   = 1'b1;
        m_rdata     = '0;
        m_err_to    = 1'b1;
        m_busy      = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (dc_resp_valid) m_err_sp = 1'b1;
      if (w >= 0) begin
        m_addr   = rq_addr[w*ADDR_W +: ADDR_W];
        m_write  = rq_write[w];
        m_wdata  = rq_wdata[w*DATA_W +: DATA_W];
        m_owner  = w;
        m_ptr    = (w + 1) % int'(NREQ);
        m_age    = 0;
        m_busy   = 1;
        plan_lat = next_lat;
        grant_log.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    spur = 0;
  endtask

  initial begin
    rst_n = 1'b0; rq_valid = '0; rq_addr = '0; rq_write = '0; rq_wdata = '0;
    dc_resp_valid = 1'b0; dc_resp_rdata = '0;
    spur = 0; plan_lat = 1000; next_lat = 1; resp_data = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", rsp_rdata, 64'(0));
    chk("rst_dc_req_valid", 64'(dc_req_valid), 64'(0));
    chk("rst_dc_req_addr", 64'(dc_req_addr), 64'(0));
    chk("rst_err_flags", 64'({err_timeout, err_spurious}), 64'(0));
    rst_n = 1'b1;

    // Single load from requester 2, cache hit
    set_req(2, 32'h100, 1'b0, 64'h0);
    rq_valid = 4'b0100; next_lat = 1;
    step();
    rq_valid = '0;
    step();
    resp_data = 64'hDEAD_BEEF;
    step();
    chk("load_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("load_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
    step();

    // Reset while BUSY drops the cache request without a clock edge
    set_req(2, 32'h200, 1'b1, 64'h1234);
    rq_valid = 4'b0100; next_lat = 1000;
    step();
    rq_valid = '0;
    step();
    chk("busy_dc_req_valid", 64'(dc_req_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_drop_dc_req_valid", 64'(dc_req_valid), 64'(0));
    chk("rst_drop_rsp_valid", 64'(rsp_valid), 64'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();

    // All requesters held: grant order starts at 0 after reset
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 32'h1000 + 32'(i), 1'b0, 64'(i));
    rq_valid = 4'b1111; next_lat = 1;
    for (int c = 0; c < 40; c++) if (grant_log.size() < 8) step();
    chk("rr_accepts", 64'(grant_log.size()), 64'(8));
    for (int k = 0; k < 8; k++)
      if (k < grant_log.size()) chk("rr_order", 64'(grant_log[k]), 64'(k % 4));
    rq_valid = '0;
    repeat (4) step();

    // Miss: cache answers 20 cycles after the request appears
    set_req(0, 32'hCAFE_0000, 1'b1, 64'hFEED_FACE_0123_4567);
    rq_valid = 4'b0001; next_lat = 20;
    step();
    rq_valid = 4'b1110; next_lat = 1; resp_data = 64'h55AA;
    repeat (21) step();
    chk("miss_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    rq_valid = '0;
    repeat (6) step();

    // Watchdog retire, then a normal request
    rq_valid = 4'b0010; next_lat = 1000;
    step();
    rq_valid = '0;
    repeat (TO) step();
    chk("to_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("to_rsp_err", 64'(rsp_err), 64'(1));
    chk("to_err_timeout", 64'(err_timeout), 64'(1));
    rq_valid = 4'b0001; next_lat = 1; resp_data = 64'h0BAD_F00D;
    step();
    rq_valid = '0;
    repeat (4) step();

    // Spurious response in IDLE
    spur = 1;
    step();
    chk("spur_flag", 64'(err_spurious), 64'(1));
    chk("spur_no_rsp", 64'(rsp_valid), 64'(0));
    step();

    // Response in the timeout cycle wins
    rq_valid = 4'b0100; next_lat = int'(TO) - 1; resp_data = 64'h7777;
    step();
    rq_valid = '0;
    repeat (TO) step();
    chk("race_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("race_rsp_err", 64'(rsp_err), 64'(0));
    step();

    // Randomized traffic
    repeat (400) begin
      rq_valid = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < int'(NREQ); i++)
        set_req(i, $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      case ($urandom_range(0, 7))
        0, 1:    next_lat = 1;
        2:       next_lat = 2;
        3:       next_lat = 3;
        4:       next_lat = 5;
        5:       next_lat = int'(TO) - 1;
        6:       next_lat = int'(TO);
        default: next_lat = 1000;
      endcase
      spur      = ($urandom_range(0, 15) == 0);
      resp_data = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
